miner_work_ctrl: RTL

Host-side controller that drives the miner core and drains its results. It assembles 44-byte work frames from a host byte stream into the 352-bit block word and pulses the miner's reset to load them. It captures golden_nonce_found pulses from the miner into a small FIFO. It returns each nonce to the host as a 5-byte packet over a valid/ready byte stream.

---
 rtl/miner_work_ctrl_if.sv | 27 ++
 rtl/miner_work_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/miner_work_ctrl_if.sv
// Host/miner bundle for the work controller: rx byte stream in, block word
// and load pulse out, miner nonce reports in, tx result byte stream out.
interface miner_work_ctrl_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [351:0] block;
    logic         miner_reset;
    logic [31:0]  golden_nonce;
    logic         golden_nonce_found;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         overflow;
    logic         busy;

    // Environment side: host and miner driving the controller
    modport master (
        output rx_data, rx_valid, golden_nonce, golden_nonce_found, tx_ready,
        input  block, miner_reset, tx_data, tx_valid, overflow, busy
    );

    // Controller side
    modport slave (
        input  rx_data, rx_valid, golden_nonce, golden_nonce_found, tx_ready,
        output block, miner_reset, tx_data, tx_valid, overflow, busy
    );
endinterface

// File: rtl/miner_work_ctrl.sv
// Work controller between host and miner core: assembles 44-byte work frames
// into the 352-bit block word, queues golden nonces and returns them to the
// host as 5-byte packets (A5 header followed by the nonce MSB first).
module miner_work_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            reset,
    miner_work_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(RX_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);
    localparam logic [5:0]    LAST_BYTE = 6'd43;

    typedef enum logic [2:0] {IDLE, HDR, B3, B2, B1, B0} tx_state_t;

    logic [351:0]  shadow_q, shadow_d;
    logic [351:0]  block_q, block_d;
    logic [5:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          miner_reset_q, miner_reset_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    tx_state_t     state_q, state_d;
    logic [31:0]   packet_q, packet_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_req;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    // The load-pulse cycle flushes the queue, so nothing is popped or pushed then
    assign pop        = (state_q == IDLE) && !fifo_empty && !miner_reset_q;
    assign push_req   = bus.golden_nonce_found && !miner_reset_q;

    // Rx assembly: shift bytes MSB-first, publish the frame on byte 44, drop stale partial frames
    always_comb begin
        shadow_d      = shadow_q;
        block_d       = block_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        miner_reset_d = 1'b0;
        if (bus.rx_valid) begin
            shadow_d   = {shadow_q[343:0], bus.rx_data};
            idle_cnt_d = '0;
            if (byte_cnt_q == LAST_BYTE) begin
                block_d       = shadow_d;
                miner_reset_d = 1'b1;
                byte_cnt_d    = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 6'd1;
            end
        end else if (byte_cnt_q != 6'd0) begin
            if (idle_cnt_q == IDLE_LAST) begin
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + IW'(1);
            end
        end
    end

    // Nonce FIFO: flush on new work, accept a push into a full queue only when a pop frees a slot
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (miner_reset_q) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_req) begin
                if (!fifo_full || pop) begin
                    mem_d[wr_idx] = bus.golden_nonce;
                    wr_ptr_d      = wr_ptr_q + PW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Tx packet FSM: header then nonce bytes, each held until the host accepts it
    always_comb begin
        state_d    = state_q;
        packet_d   = packet_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (pop) begin
                    packet_d   = mem_q[rd_idx];
                    state_d    = HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hA5;
                end
            end
            HDR: if (tx_valid_q && bus.tx_ready) begin
                state_d   = B3;
                tx_data_d = packet_q[31:24];
            end
            B3: if (tx_valid_q && bus.tx_ready) begin
                state_d   = B2;
                tx_data_d = packet_q[23:16];
            end
            B2: if (tx_valid_q && bus.tx_ready) begin
                state_d   = B1;
                tx_data_d = packet_q[15:8];
            end
            B1: if (tx_valid_q && bus.tx_ready) begin
                state_d   = B0;
                tx_data_d = packet_q[7:0];
            end
            B0: if (tx_valid_q && bus.tx_ready) begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // State registers; reset abandons frames, queued nonces and any packet in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            block_q       <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            miner_reset_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            state_q       <= IDLE;
            packet_q      <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            block_q       <= block_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            miner_reset_q <= miner_reset_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            packet_q      <= packet_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
        end
        mem_q <= mem_d;
    end

    assign bus.block       = block_q;
    assign bus.miner_reset = miner_reset_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (byte_cnt_q != 6'd0);
endmodule
